// File: rtl/ethernet_fmc_clk_rst_ctrl.sv
// Clock/reset sequencer for an Ethernet FMC MMCM: pulses the MMCM reset, waits for lock,
// requires lock to stay stable, then releases the downstream reset and counts lock events.
module ethernet_fmc_clk_rst_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 131072,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             locked_async,
  input  logic             force_restart,
  output logic             mmcm_reset,
  output logic             sys_reset,
  output logic             ready,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int MAX_RT = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0]    RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STAB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  typedef enum logic [1:0] {S_RST, S_WAIT, S_STAB, S_RUN} state_t;

  state_t          state, state_nxt;
  logic            sync0, locked_s;
  logic [CW-1:0]   cnt;
  logic            loss_inc, timeout_inc;

  // Lock wins over timeout in WAIT; force_restart overrides every transition.
  always_comb begin
    state_nxt   = state;
    loss_inc    = 1'b0;
    timeout_inc = 1'b0;
    if (force_restart) begin
      state_nxt = S_RST;
    end else begin
      case (state)
        S_RST:  if (cnt == RST_LAST) state_nxt = S_WAIT;
        S_WAIT: begin
          if (locked_s) begin
            state_nxt = S_STAB;
          end else if (cnt == LOCK_LAST) begin
            state_nxt   = S_RST;
            timeout_inc = 1'b1;
          end
        end
        S_STAB: begin
          if (!locked_s)              state_nxt = S_WAIT;
          else if (cnt == STAB_LAST)  state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            state_nxt = S_RST;
            loss_inc  = 1'b1;
          end
        end
        default: state_nxt = S_RST;
      endcase
    end
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0       <= 1'b0;
      locked_s    <= 1'b0;
      state       <= S_RST;
      cnt         <= '0;
      mmcm_reset  <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      loss_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      sync0    <= locked_async;
      locked_s <= sync0;
      state    <= state_nxt;
      // RUN has no timed exit, so its counter is held to avoid wrapping.
      if (force_restart || (state_nxt != state)) cnt <= '0;
      else if (state != S_RUN)                   cnt <= cnt + CW'(1);
      mmcm_reset <= (state_nxt == S_RST);
      sys_reset  <= (state_nxt != S_RUN);
      ready      <= (state_nxt == S_RUN);
      if (loss_inc && (loss_cnt != EVT_MAX))          loss_cnt    <= loss_cnt + CNT_W'(1);
      if (timeout_inc && (timeout_cnt != EVT_MAX))    timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ethernet_fmc_clk_rst_ctrl.sv
// Self-checking bench: a phase/elapsed-time reference model is compared against the DUT
// after every clock, plus directed literal checks of the headline timing scenarios.
module tb_ethernet_fmc_clk_rst_ctrl;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int CW = 4;
  localparam int EVT_MAX = (1 << CW) - 1;

  localparam int P_RESETTING = 0;
  localparam int P_WAITING   = 1;
  localparam int P_SETTLING  = 2;
  localparam int P_RUNNING   = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          locked_async = 1'b0;
  logic          force_restart = 1'b0;
  logic          mmcm_reset, sys_reset, ready;
  logic [CW-1:0] loss_cnt, timeout_cnt;

  int assertions = 0;
  int failures = 0;

  int m_phase = P_RESETTING;
  int m_elapsed = 0;
  int m_loss = 0;
  int m_timeout = 0;
  bit m_lock_pipe[$] = '{1'b0, 1'b0};

  ethernet_fmc_clk_rst_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .locked_async(locked_async), .force_restart(force_restart),
    .mmcm_reset(mmcm_reset), .sys_reset(sys_reset), .ready(ready),
    .loss_cnt(loss_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void enter(input int phase);
    m_phase   = phase;
    m_elapsed = 0;
  endfunction

  // Reference: lock seen by decisions is the input from two edges ago; each phase has a length.
  function automatic void modelStep(input bit r, input bit l, input bit f);
    bit seen;
    if (r) begin
      enter(P_RESETTING);
      m_loss = 0;
      m_timeout = 0;
      m_lock_pipe = '{1'b0, 1'b0};
      return;
    end
    seen = m_lock_pipe.pop_front();
    m_lock_pipe.push_back(l);
    if (f) begin
      enter(P_RESETTING);
      return;
    end
    m_elapsed++;
    case (m_phase)
      P_RESETTING: if (m_elapsed >= RC) enter(P_WAITING);
      P_WAITING: begin
        if (seen) enter(P_SETTLING);
        else if (m_elapsed >= LT) begin
          enter(P_RESETTING);
          if (m_timeout < EVT_MAX) m_timeout++;
        end
      end
      P_SETTLING: begin
        if (!seen) enter(P_WAITING);
        else if (m_elapsed >= SC) enter(P_RUNNING);
      end
      default: begin
        if (!seen) begin
          enter(P_RESETTING);
          if (m_loss < EVT_MAX) m_loss++;
        end
      end
    endcase
  endfunction

  task automatic checkOutput();
    cmp("model_mmcm_reset", mmcm_reset, (m_phase == P_RESETTING));
    cmp("model_sys_reset", sys_reset, (m_phase != P_RUNNING));
    cmp("model_ready", ready, (m_phase == P_RUNNING));
    cmp("model_loss_cnt", loss_cnt, m_loss);
    cmp("model_timeout_cnt", timeout_cnt, m_timeout);
  endtask

  task automatic applyStimulus(input bit r, input bit l, input bit f);
    reset = r;
    locked_async = l;
    force_restart = f;
    @(posedge clk);
    modelStep(r, l, f);
    #1;
    checkOutput();
  endtask

  task automatic runUntilReady(input string name);
    int n = 0;
    while (!ready && n < 100) begin
      applyStimulus(0, 1, 0);
      n++;
    end
    if (!ready) begin
      failures++;
      $display("[TB] FAIL %s: ready got 0, expected 1 within 100 cycles", name);
    end
  endtask

  initial begin
    int highs;
    int n;
    bit lk;
    int hold;

    // Lock never arrives: 4 high / 32 low periods, timeout count saturates.
    applyStimulus(1, 0, 0);
    cmp("reset_mmcm", mmcm_reset, 1);
    cmp("reset_sys", sys_reset, 1);
    cmp("reset_ready", ready, 0);
    highs = int'(mmcm_reset);
    for (int i = 1; i < 600; i++) begin
      applyStimulus(0, 0, 0);
      if (i < 72) highs += int'(mmcm_reset);
      if (i == 3)  cmp("mmcm_last_high", mmcm_reset, 1);
      if (i == 4)  cmp("mmcm_first_low", mmcm_reset, 0);
      if (i == 35) cmp("wait_last_low", mmcm_reset, 0);
      if (i == 36) begin
        cmp("restart_mmcm", mmcm_reset, 1);
        cmp("first_timeout", timeout_cnt, 1);
      end
    end
    cmp("period_highs", highs, 8);
    cmp("timeout_saturated", timeout_cnt, 15);

    // Lock 10 cycles after mmcm_reset falls, run, then lose lock.
    applyStimulus(1, 0, 0);
    for (int i = 1; i <= 37; i++) begin
      applyStimulus(0, (i >= 14 && i < 31), 0);
      if (i == 23) cmp("stab_not_ready", ready, 0);
      if (i == 24) begin
        cmp("run_ready", ready, 1);
        cmp("run_sys_reset", sys_reset, 0);
        cmp("run_timeout_zero", timeout_cnt, 0);
      end
      if (i == 32) cmp("loss_still_ready", ready, 1);
      if (i == 33) begin
        cmp("loss_ready_drop", ready, 0);
        cmp("loss_mmcm", mmcm_reset, 1);
        cmp("loss_count", loss_cnt, 1);
      end
      if (i == 36) cmp("loss_rst_last", mmcm_reset, 1);
      if (i == 37) cmp("loss_rst_end", mmcm_reset, 0);
    end

    // Glitch during STAB, relock, full STAB again, then force_restart from RUN.
    applyStimulus(1, 0, 0);
    highs = 0;
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(0, (i >= 14) && !(i >= 18 && i <= 20), (i == 32));
      if (i >= 17 && i <= 30) highs += int'(ready);
      if (i == 31) begin
        cmp("glitch_run_ready", ready, 1);
        cmp("glitch_loss_zero", loss_cnt, 0);
      end
      if (i == 32) begin
        cmp("force_mmcm", mmcm_reset, 1);
        cmp("force_ready", ready, 0);
        cmp("force_loss_kept", loss_cnt, 0);
        cmp("force_timeout_kept", timeout_cnt, 0);
      end
    end
    cmp("glitch_ready_cycles", highs, 0);

    // Drive loss_cnt to saturation, then reset from RUN.
    for (int k = 0; k < 17; k++) begin
      runUntilReady("sat_reach_run");
      n = 0;
      while (ready && n < 10) begin
        applyStimulus(0, 0, 0);
        n++;
      end
    end
    cmp("loss_saturated", loss_cnt, 15);
    runUntilReady("sat_final_run");
    applyStimulus(1, 1, 0);
    cmp("rst_from_run_mmcm", mmcm_reset, 1);
    cmp("rst_from_run_ready", ready, 0);
    cmp("rst_from_run_loss", loss_cnt, 0);

    // Randomised phase: lock held for random stretches, occasional restart/reset.
    applyStimulus(1, 0, 0);
    lk = 1'b0;
    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      if (hold == 0) begin
        lk = ($urandom_range(0, 3) != 0);
        hold = lk ? $urandom_range(1, 40) : $urandom_range(1, 12);
      end
      hold--;
      applyStimulus(($urandom_range(0, 799) == 0), lk, ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/ethernet_fmc_clk_rst_ctrl.md
ETHERNET_FMC_CLK_RST_CTRL -- requirements
Module: ethernet_fmc_clk_rst_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, cycles mmcm_reset is held high per restart (>=2).
REQ-002 Parameter LOCK_TIMEOUT, default 131072, cycles allowed for lock before MMCM is reset again (>=4).
REQ-003 Parameter STABLE_CYCLES, default 1024, cycles locked must stay high before downstream reset release (>=2).
REQ-004 Parameter CNT_W, default 8, width of the saturating event counters.
REQ-005 clk  input  1  free-running reference clock driving the MMCM input; sole clock of the block.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 locked_async  input  1  MMCM locked status, asynchronous to clk.
REQ-008 force_restart  input  1  single-cycle request to restart the MMCM sequence.
REQ-009 mmcm_reset  output  1  reset to the MMCM RST pin.
REQ-010 sys_reset  output  1  active-high reset for logic on the generated clocks.
REQ-011 ready  output  1  high only while clocks are locked and stable.
REQ-012 loss_cnt  output  CNT_W  saturating count of lock losses while in RUN.
REQ-013 timeout_cnt  output  CNT_W  saturating count of lock timeouts in WAIT.

Function
REQ-014 locked_async SHALL pass through a 2-flop synchronizer; locked_s is locked_async delayed 2 clk cycles, and all FSM decisions SHALL use locked_s only.
REQ-015 FSM states SHALL be RST, WAIT, STAB, RUN, with one shared cycle counter cleared on every state change.
REQ-016 Outputs SHALL be Moore decodes of the registered state: mmcm_reset=1 only in RST; sys_reset=0 and ready=1 only in RUN.
REQ-017 RST: counter increments each cycle; at counter==RST_CYCLES-1 go to WAIT, so mmcm_reset is high exactly RST_CYCLES cycles.
REQ-018 WAIT: if locked_s go to STAB; else at counter==LOCK_TIMEOUT-1 go to RST and increment timeout_cnt.
REQ-019 STAB: if !locked_s go to WAIT (no counter increment, timeout counter restarts); else at counter==STABLE_CYCLES-1 go to RUN.
REQ-020 RUN: if !locked_s go to RST and increment loss_cnt; sys_reset reasserts and ready drops in the cycle after locked_s is sampled low.
REQ-021 force_restart SHALL, in any state, move to RST on the next edge without incrementing either counter; priority reset > force_restart > state transitions.
REQ-022 force_restart asserted during RST SHALL restart the RST count from 0.
REQ-023 loss_cnt and timeout_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 In WAIT, locked_s and timeout on the same cycle: locked_s wins (go to STAB, no timeout count).
REQ-025 Counter width SHALL be sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES); no overflow at any legal parameter value.

Reset
REQ-026 On reset high at a clk edge: state=RST, counter=0, synchronizer flops=0, loss_cnt=0, timeout_cnt=0; hence mmcm_reset=1, sys_reset=1, ready=0 from the next cycle.
REQ-027 reset asserted mid-operation (any state) SHALL take effect on the same edge and clear both event counters.
REQ-028 The first RST count SHALL start in the first cycle after reset deasserts.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, CNT_W=4)
REQ-029 Reset then locked_async held 0 -> mmcm_reset high 4 cycles, low 32 cycles, repeating; timeout_cnt increments each period, saturates at 15.
REQ-030 Reset, locked_async rises 10 cycles after mmcm_reset falls -> STAB entered 2 cycles later; ready=1, sys_reset=0 exactly 8 cycles after STAB entry; counters stay 0.
REQ-031 In STAB, locked_async glitches low for 3 cycles -> return to WAIT, ready stays 0, loss_cnt=0, STAB restarts its full 8 cycles after relock.
REQ-032 In RUN, locked_async falls -> 2 sync cycles later state goes to RST, ready=0, sys_reset=1, mmcm_reset=1 for 4 cycles; loss_cnt=1.
REQ-033 In RUN, force_restart pulsed -> next cycle mmcm_reset=1, ready=0; loss_cnt and timeout_cnt unchanged.
REQ-034 In RUN with loss_cnt=15, reset pulsed -> all outputs return to reset values, loss_cnt=0.
